// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position controller: synchronized/debounced buttons, v-sync tick,
// clamped X/Y motion and recenter. Define SPRITE_ACCEL_EN to build hold-to-accelerate.
module sprite_motion_ctrl #(
  parameter int SCREEN_W     = 800,
  parameter int SCREEN_H     = 600,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int DB_CYCLES    = 500000,
  parameter int ACCEL_FRAMES = 30,
  parameter int MAX_STEP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_v_sync,
  input  logic        i_btn_x,
  input  logic        i_btn_y,
  input  logic        i_dir,
  input  logic        i_home,
  output logic [15:0] o_sprite_x,
  output logic [15:0] o_sprite_y,
  output logic        o_frame_tick,
  output logic        o_at_edge_x,
  output logic        o_at_edge_y,
  output logic [2:0]  o_step
);
  localparam logic [15:0] XL      = 16'(SCREEN_W - SPRITE_W);
  localparam logic [15:0] YL      = 16'(SCREEN_H - SPRITE_H);
  localparam logic [15:0] XC      = XL >> 1;
  localparam logic [15:0] YC      = YL >> 1;
  localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || DB_CYCLES > 1048575 || MAX_STEP < 1 || MAX_STEP > 7 ||
      ACCEL_FRAMES < 1) begin : g_bad_cfg
    $error("sprite_motion_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} state_t;

  function automatic logic [15:0] step_inc(input logic [15:0] pos, input logic [2:0] st,
                                           input logic [15:0] lim);
    logic [16:0] sum;
    sum = {1'b0, pos} + {14'd0, st};
    return (sum > {1'b0, lim}) ? lim : sum[15:0];
  endfunction

  function automatic logic [15:0] step_dec(input logic [15:0] pos, input logic [2:0] st);
    return (pos < {13'd0, st}) ? 16'd0 : pos - {13'd0, st};
  endfunction

  // Bit order {dir, btn_y, btn_x, v_sync}. V-sync stages reset high so a level already
  // present when reset releases is never seen as a rising edge.
  logic [3:0] sync1_q, sync2_q;
  logic       vs_prev_q, tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 4'b0001;
      sync2_q   <= 4'b0001;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      sync1_q   <= {i_dir, i_btn_y, i_btn_x, i_v_sync};
      sync2_q   <= sync1_q;
      vs_prev_q <= sync2_q[0];
      tick_q    <= sync2_q[0] & ~vs_prev_q;
    end
  end

  logic [1:0]       db_q;
  logic [1:0][19:0] db_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i+1] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i+1];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 20'd1;
        end
      end
    end
  end

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        edge_x_q, edge_y_q;
  logic        mv_x, mv_y;
  logic [2:0]  cur_step;
  logic [15:0] pos, lim, new_pos;
  logic        dir_s;

  assign dir_s = sync2_q[3];

`ifdef SPRITE_ACCEL_EN
  localparam logic [2:0]  MAX_S     = 3'(MAX_STEP);
  localparam logic [15:0] HOLD_LAST = 16'(ACCEL_FRAMES - 1);
  logic [2:0]  step_q, step_d;
  logic [15:0] hold_q, hold_d, hold_eff;
  logic        dir_last_q, dir_last_d;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mv_x     = 1'b0;
    mv_y     = 1'b0;
    cur_step = 3'd1;
    pos      = x_q;
    lim      = XL;
    new_pos  = x_q;
`ifdef SPRITE_ACCEL_EN
    step_d     = step_q;
    hold_d     = hold_q;
    hold_eff   = hold_q;
    dir_last_d = dir_last_q;
    cur_step   = step_q;
`endif
    if (tick_q) begin
      if (i_home) begin
        x_d     = XC;
        y_d     = YC;
        state_d = IDLE;
`ifdef SPRITE_ACCEL_EN
        step_d  = 3'd1;
        hold_d  = '0;
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            if (db_q[0]) begin
              state_d = MOVE_X;
              mv_x    = 1'b1;
            end else if (db_q[1]) begin
              state_d = MOVE_Y;
              mv_y    = 1'b1;
            end
          end
          MOVE_X: begin
            if (!db_q[0]) begin
              state_d = IDLE;
`ifdef SPRITE_ACCEL_EN
              step_d  = 3'd1;
              hold_d  = '0;
`endif
            end else begin
              mv_x = 1'b1;
            end
          end
          MOVE_Y: begin
            if (!db_q[1]) begin
              state_d = IDLE;
`ifdef SPRITE_ACCEL_EN
              step_d  = 3'd1;
              hold_d  = '0;
`endif
            end else begin
              mv_y = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (mv_x || mv_y) begin
`ifdef SPRITE_ACCEL_EN
      // A reversal restarts acceleration before this frame's move is taken.
      if (dir_s != dir_last_q) begin
        cur_step = 3'd1;
        hold_eff = '0;
      end
      dir_last_d = dir_s;
      if (hold_eff == HOLD_LAST) begin
        hold_d = '0;
        step_d = (cur_step >= MAX_S) ? MAX_S : cur_step + 3'd1;
      end else begin
        hold_d = hold_eff + 16'd1;
        step_d = cur_step;
      end
`endif
      pos     = mv_x ? x_q : y_q;
      lim     = mv_x ? XL : YL;
      new_pos = dir_s ? step_inc(pos, cur_step, lim) : step_dec(pos, cur_step);
      if (mv_x) x_d = new_pos;
      else      y_d = new_pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      edge_x_q <= 1'b1;
      edge_y_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      edge_x_q <= (x_d == 16'd0) || (x_d == XL);
      edge_y_q <= (y_d == 16'd0) || (y_d == YL);
    end
  end

`ifdef SPRITE_ACCEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q     <= 3'd1;
      hold_q     <= '0;
      dir_last_q <= 1'b0;
    end else begin
      step_q     <= step_d;
      hold_q     <= hold_d;
      dir_last_q <= dir_last_d;
    end
  end
  assign o_step = step_q;
`else
  assign o_step = 3'd1;
`endif

  assign o_sprite_x   = x_q;
  assign o_sprite_y   = y_q;
  assign o_frame_tick = tick_q;
  assign o_at_edge_x  = edge_x_q;
  assign o_at_edge_y  = edge_y_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: vector table plus hand sequences for clamping,
// debounce glitch, recenter and asynchronous reset.
module tb_sprite_motion_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic        btn_x = 1'b0;
  logic        btn_y = 1'b0;
  logic        dir = 1'b1;
  logic        home = 1'b0;
  logic [15:0] o_sprite_x, o_sprite_y;
  logic        o_frame_tick, o_at_edge_x, o_at_edge_y;
  logic [2:0]  o_step;

  int checks = 0;
  int failures = 0;
  int px, py;
  logic pex, pey;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.DB_CYCLES(4), .ACCEL_FRAMES(2), .MAX_STEP(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_v_sync(v_sync), .i_btn_x(btn_x), .i_btn_y(btn_y),
    .i_dir(dir), .i_home(home), .o_sprite_x(o_sprite_x), .o_sprite_y(o_sprite_y),
    .o_frame_tick(o_frame_tick), .o_at_edge_x(o_at_edge_x), .o_at_edge_y(o_at_edge_y),
    .o_step(o_step)
  );

  typedef struct {
    logic bx; logic by; logic dr; logic hm;
    int x; int y; logic eex; logic eey; int st;
  } vec_t;

  function automatic vec_t mk(input logic bx, input logic by, input logic dr, input logic hm,
                              input int x, input int y, input logic eex, input logic eey,
                              input int st);
    vec_t v;
    v.bx = bx; v.by = by; v.dr = dr; v.hm = hm;
    v.x = x; v.y = y; v.eex = eex; v.eey = eey; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int x, input int y, input logic eex,
                         input logic eey, input int st);
    chk({tag, ".x"}, {16'd0, o_sprite_x}, x);
    chk({tag, ".y"}, {16'd0, o_sprite_y}, y);
    chk({tag, ".edge_x"}, {31'd0, o_at_edge_x}, {31'd0, eex});
    chk({tag, ".edge_y"}, {31'd0, o_at_edge_y}, {31'd0, eey});
    chk({tag, ".step"}, {29'd0, o_step}, st);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  // One v-sync pulse; exactly one tick cycle must appear within the pulse window.
  task automatic frame();
    int seen;
    seen = 0;
    @(negedge clk) v_sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_frame_tick) seen++;
    end
    v_sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_frame_tick) seen++;
    end
    chk("frame_tick_count", seen, 1);
  endtask

`ifndef SPRITE_ACCEL_EN
  localparam int NV = 27;
  vec_t tv [NV];
`else
  int ax [7] = '{1, 2, 4, 6, 9, 12, 15};
  int as [7] = '{1, 2, 2, 3, 3, 3, 3};
`endif

  initial begin
`ifndef SPRITE_ACCEL_EN
    for (int i = 0; i < 3; i++)   tv[i] = mk(0, 0, 1, 0, 0, 0, 1, 1, 1);
    for (int i = 3; i < 13; i++)  tv[i] = mk(1, 0, 1, 0, i - 2, 0, 0, 1, 1);
    tv[13] = mk(0, 0, 1, 0, 10, 0, 0, 1, 1);
    for (int i = 14; i < 18; i++) tv[i] = mk(1, 1, 1, 0, i - 3, 0, 0, 1, 1);
    tv[18] = mk(0, 1, 1, 0, 14, 0, 0, 1, 1);
    tv[19] = mk(0, 1, 1, 0, 14, 1, 0, 0, 1);
    tv[20] = mk(0, 1, 1, 0, 14, 2, 0, 0, 1);
    tv[21] = mk(1, 1, 1, 0, 14, 3, 0, 0, 1);
    tv[22] = mk(0, 0, 1, 0, 14, 3, 0, 0, 1);
    tv[23] = mk(0, 0, 1, 1, 392, 292, 0, 0, 1);
    tv[24] = mk(0, 1, 0, 0, 392, 291, 0, 0, 1);
    tv[25] = mk(0, 1, 0, 0, 392, 290, 0, 0, 1);
    tv[26] = mk(0, 0, 0, 0, 392, 290, 0, 0, 1);
`endif

    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 1, 1, 1);
    chk("reset.tick", {31'd0, o_frame_tick}, 0);
    rst_n = 1'b1;
    settle();

    @(negedge clk) v_sync = 1'b1;
    @(negedge clk) chk("tick_c1", {31'd0, o_frame_tick}, 0);
    @(negedge clk) chk("tick_c2", {31'd0, o_frame_tick}, 0);
    @(negedge clk) chk("tick_c3", {31'd0, o_frame_tick}, 1);
    v_sync = 1'b0;
    @(negedge clk) chk("tick_c4", {31'd0, o_frame_tick}, 0);
    repeat (3) @(negedge clk);
    chk_out("first_tick", 0, 0, 1, 1, 1);

`ifndef SPRITE_ACCEL_EN
    for (int i = 0; i < NV; i++) begin
      btn_x = tv[i].bx; btn_y = tv[i].by; dir = tv[i].dr; home = tv[i].hm;
      settle();
      frame();
      home = 1'b0;
      chk_out($sformatf("vec%0d", i), tv[i].x, tv[i].y, tv[i].eex, tv[i].eey, tv[i].st);
    end

    btn_x = 1'b1; dir = 1'b1;
    settle();
    for (int i = 0; i < 390; i++) frame();
    chk_out("clamp_782", 782, 290, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      frame();
      chk_out($sformatf("clamp_hi%0d", i), (i == 0) ? 783 : 784, 290, i != 0, 0, 1);
    end

    dir = 1'b0; home = 1'b1;
    settle();
    frame();
    home = 1'b0;
    chk_out("home_mid", 392, 292, 0, 0, 1);
    for (int i = 0; i < 392; i++) frame();
    chk_out("clamp_0", 0, 292, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      frame();
      chk_out($sformatf("clamp_lo%0d", i), 0, 292, 1, 0, 1);
    end
    px = 0; py = 292; pex = 1'b1; pey = 1'b0;
`else
    btn_x = 1'b1; dir = 1'b1;
    settle();
    for (int i = 0; i < 7; i++) begin
      frame();
      chk_out($sformatf("accel%0d", i), ax[i], 0, 0, 1, as[i]);
    end
    dir = 1'b0;
    settle();
    frame();
    chk_out("flip1", 14, 0, 0, 1, 1);
    frame();
    chk_out("flip2", 13, 0, 0, 1, 2);
    px = 13; py = 0; pex = 1'b0; pey = 1'b1;
`endif

    btn_x = 1'b0; btn_y = 1'b0; dir = 1'b1;
    settle();
    frame();
    chk_out("release", px, py, pex, pey, 1);

    @(negedge clk) btn_x = 1'b1;
    repeat (3) @(negedge clk);
    btn_x = 1'b0;
    frame();
    chk_out("glitch", px, py, pex, pey, 1);

    home = 1'b1;
    frame();
    home = 1'b0;
    chk_out("home", 392, 292, 0, 0, 1);

    btn_x = 1'b1;
    settle();
    frame();
    chk_out("pre_reset", 393, 292, 0, 0, 1);

    begin
      int seen;
      seen = 0;
      @(negedge clk) v_sync = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_out("in_reset", 0, 0, 1, 1, 1);
      chk("in_reset.tick", {31'd0, o_frame_tick}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (o_frame_tick) seen++;
      end
      chk("stale_vsync_ticks", seen, 0);
      v_sync = 1'b0;
      repeat (3) @(negedge clk);
      chk_out("post_reset", 0, 0, 1, 1, 1);
    end

    frame();
    chk_out("post_reset_move", 1, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
